// File: rtl/exe_stage_if.sv
// Execute-stage port bundle: decode-side handshake and bundle, memory-side
// handshake and bundle, forwarding bundle back to decode, and data-SRAM request.
interface exe_stage_if;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [153:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  // Surrounding pipeline / testbench side
  modport master (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  // Execute stage side
  modport slave (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: pipeline register, ALU, 32-step restoring divider for
// div.w/mod.w/div.wu/mod.wu, data-SRAM request and forwarding bundle.
//
// Handshake: a transfer happens on a rising edge where the producer's valid
// and the consumer's allowin are both high. ds_to_es_valid && es_allowin
// captures a new bundle; es_to_ms_valid && ms_allowin hands the result on.
// es_to_ms_valid never depends on ms_allowin.
module exe_stage (
  input  logic        clk,
  input  logic        resetn,
  exe_stage_if.slave  bus,
  output logic [1:0]  o_dbg_div_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  div_state_t   r_state;
  div_state_t   w_state_next;
  logic         r_es_valid;
  logic [153:0] r_ds_bus;
  logic [4:0]   r_cnt;
  logic [32:0]  r_rem;
  logic [31:0]  r_quo;
  logic [31:0]  r_dvd;
  logic [31:0]  r_dvs;
  logic         r_rj_neg;
  logic         r_rk_neg;

  // Bundle fields
  logic [3:0]  w_div_op;
  logic [11:0] w_alu_op;
  logic        w_load_op, w_src1_is_pc, w_src2_is_imm, w_gr_we, w_mem_we;
  logic [4:0]  w_dest;
  logic [31:0] w_imm, w_rj, w_rkd, w_pc;
  assign {w_div_op, w_alu_op, w_load_op, w_src1_is_pc, w_src2_is_imm, w_gr_we,
          w_mem_we, w_dest, w_imm, w_rj, w_rkd, w_pc} = r_ds_bus;

  // ALU
  logic [31:0] w_src1, w_src2, w_alu_result;
  logic [31:0] w_add, w_sub, w_slt, w_sltu, w_sra;
  assign w_src1 = w_src1_is_pc  ? w_pc  : w_rj;
  assign w_src2 = w_src2_is_imm ? w_imm : w_rkd;
  assign w_add  = w_src1 + w_src2;
  assign w_sub  = w_src1 - w_src2;
  assign w_slt  = {31'b0, $signed(w_src1) < $signed(w_src2)};
  assign w_sltu = {31'b0, w_src1 < w_src2};
  assign w_sra  = $unsigned($signed(w_src1) >>> w_src2[4:0]);
  assign w_alu_result = ({32{w_alu_op[0]}}  & w_add)
                      | ({32{w_alu_op[1]}}  & w_sub)
                      | ({32{w_alu_op[2]}}  & w_slt)
                      | ({32{w_alu_op[3]}}  & w_sltu)
                      | ({32{w_alu_op[4]}}  & (w_src1 & w_src2))
                      | ({32{w_alu_op[5]}}  & ~(w_src1 | w_src2))
                      | ({32{w_alu_op[6]}}  & (w_src1 | w_src2))
                      | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2))
                      | ({32{w_alu_op[8]}}  & (w_src1 << w_src2[4:0]))
                      | ({32{w_alu_op[9]}}  & (w_src1 >> w_src2[4:0]))
                      | ({32{w_alu_op[10]}} & w_sra)
                      | ({32{w_alu_op[11]}} & w_src2);

  // Stage control
  logic w_is_div, w_ready_go, w_handoff, w_signed, w_sel_quo;
  assign w_is_div   = r_es_valid && (|w_div_op);
  assign w_ready_go = !w_is_div || (r_state == S_DONE);
  assign w_handoff  = bus.es_to_ms_valid && bus.ms_allowin;
  assign w_signed   = w_div_op[0] | w_div_op[1];
  assign w_sel_quo  = w_div_op[0] | w_div_op[2];

  assign bus.es_allowin     = !r_es_valid || (w_ready_go && bus.ms_allowin);
  assign bus.es_to_ms_valid = r_es_valid && w_ready_go;

  // Divider datapath helpers: one restoring step, then sign fix-up
  logic [32:0] w_trial;
  logic [31:0] w_quo_fix, w_rem_fix, w_div_result, w_es_result;
  assign w_trial      = {r_rem[31:0], r_dvd[31]} - {1'b0, r_dvs};
  assign w_quo_fix    = (r_rj_neg ^ r_rk_neg) ? (32'd0 - r_quo) : r_quo;
  assign w_rem_fix    = r_rj_neg ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
  assign w_div_result = w_sel_quo ? w_quo_fix : w_rem_fix;
  assign w_es_result  = w_is_div ? w_div_result : w_alu_result;

  // Outputs
  assign bus.es_to_ms_bus = {w_load_op, w_gr_we, w_dest, w_es_result, w_pc};
  assign bus.es_to_ds_bus = {r_es_valid && w_gr_we, w_dest, w_es_result,
                             r_es_valid && (w_load_op || (w_is_div && r_state != S_DONE))};
  assign bus.data_sram_en    = r_es_valid && bus.ms_allowin && (w_load_op || w_mem_we);
  assign bus.data_sram_we    = {4{r_es_valid && bus.ms_allowin && w_mem_we}};
  assign bus.data_sram_addr  = w_alu_result;
  assign bus.data_sram_wdata = w_rkd;
  assign o_dbg_div_state     = r_state;

  // Pipeline register: valid follows decode whenever we can accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_es_valid <= 1'b0;
      r_ds_bus   <= '0;
    end else begin
      if (bus.es_allowin) r_es_valid <= bus.ds_to_es_valid;
      if (bus.ds_to_es_valid && bus.es_allowin) r_ds_bus <= bus.ds_to_es_bus;
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Divider next state: start needs a valid divide, done waits for handoff
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_is_div) w_state_next = S_BUSY;
      S_BUSY:  if (r_cnt == 5'd31) w_state_next = S_DONE;
      S_DONE:  if (w_handoff) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Divider datapath: latch magnitudes on start, one restoring step per BUSY cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= 5'd0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rj_neg <= 1'b0;
      r_rk_neg <= 1'b0;
    end else if (r_state == S_IDLE && w_is_div) begin
      r_rj_neg <= w_signed && w_rj[31];
      r_rk_neg <= w_signed && w_rkd[31];
      r_dvd    <= (w_signed && w_rj[31])  ? (32'd0 - w_rj)  : w_rj;
      r_dvs    <= (w_signed && w_rkd[31]) ? (32'd0 - w_rkd) : w_rkd;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= 5'd0;
    end else if (r_state == S_BUSY) begin
      r_dvd <= {r_dvd[30:0], 1'b0};
      r_cnt <= r_cnt + 5'd1;
      if (!w_trial[32]) begin
        r_rem <= w_trial;
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= {r_rem[31:0], r_dvd[31]};
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, divider results and timing,
// memory back-pressure, SRAM requests and reset during a divide.
module tb_exe_stage;

  logic       clk;
  logic       resetn;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;

  exe_stage_if bus();

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .bus             (bus.slave),
    .o_dbg_div_state (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [153:0] mk(
    input logic [3:0] div_op, input logic [11:0] alu_op, input logic load_op,
    input logic s1pc, input logic s2imm, input logic grwe, input logic memwe,
    input logic [4:0] dest, input logic [31:0] imm, input logic [31:0] rj,
    input logic [31:0] rkd, input logic [31:0] pc);
    return {div_op, alu_op, load_op, s1pc, s2imm, grwe, memwe, dest, imm, rj, rkd, pc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one bundle for one edge (stage assumed able to accept)
  task automatic issue(input logic [153:0] b);
    bus.ds_to_es_valid = 1'b1;
    bus.ds_to_es_bus   = b;
    step();
    bus.ds_to_es_valid = 1'b0;
  endtask

  function automatic logic [31:0] res();
    return bus.es_to_ms_bus[63:32];
  endfunction

  // Full divide with ms_allowin=1: stall on cycles 0..32, result on cycle 33
  task automatic run_div(input string tag, input logic [3:0] op,
                         input logic [31:0] rj, input logic [31:0] rk,
                         input logic [31:0] exp);
    issue(mk(op, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'd0, rj, rk, 32'h1c00_0040));
    for (int c = 0; c <= 32; c++) begin
      chk({tag, "_stall"}, 32'({bus.es_allowin, bus.es_to_ds_bus[0], bus.es_to_ms_valid}), 32'b010);
      step();
    end
    chk({tag, "_valid"}, 32'(bus.es_to_ms_valid), 32'd1);
    chk({tag, "_result"}, res(), exp);
    chk({tag, "_state"}, 32'(dbg_state), 32'd2);
    chk({tag, "_blk"}, 32'(bus.es_to_ds_bus[0]), 32'd0);
    step();
    chk({tag, "_empty"}, 32'({bus.es_to_ms_valid, dbg_state}), 32'd0);
  endtask

  // Directed sequence
  initial begin
    logic [31:0] held;
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    bus.ms_allowin = 1'b1;
    bus.ds_to_es_valid = 1'b0;
    bus.ds_to_es_bus = '0;
    #2;
    chk("rst_to_ms_valid", 32'(bus.es_to_ms_valid), 32'd0);
    chk("rst_allowin", 32'(bus.es_allowin), 32'd1);
    chk("rst_sram", 32'({bus.data_sram_en, bus.data_sram_we}), 32'd0);
    chk("rst_we_blk", 32'({bus.es_to_ds_bus[38], bus.es_to_ds_bus[0]}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    step();
    resetn = 1'b1;
    step();

    // addi.w 5 + 3
    issue(mk(4'b0, 12'h001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'd3, 32'd5, 32'd0, 32'h1c00_0000));
    chk("addi_valid", 32'(bus.es_to_ms_valid), 32'd1);
    chk("addi_result", res(), 32'd8);
    chk("addi_fwd", 32'({bus.es_to_ds_bus[38], bus.es_to_ds_bus[37:33], bus.es_to_ds_bus[0]}),
        32'({1'b1, 5'd3, 1'b0}));
    chk("addi_fwd_result", bus.es_to_ds_bus[32:1], 32'd8);
    step();
    chk("addi_gone", 32'(bus.es_to_ms_valid), 32'd0);

    // or.w 0xF0F0 | 0x0FF0
    issue(mk(4'b0, 12'h040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'd0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h1c00_0004));
    chk("or_result", res(), 32'h0000_FFF0);
    step();

    // Divider results
    run_div("divw", 4'b0001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("modw", 4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("divwu", 4'b0100, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
    run_div("modwu", 4'b1000, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F);
    run_div("divw_ovf", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("divwu_z", 4'b0100, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    run_div("modwu_z", 4'b1000, 32'h1234, 32'd0, 32'h0000_1234);

    // div.w -100/7 with memory stalled at completion
    bus.ms_allowin = 1'b0;
    issue(mk(4'b0001, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'd0, 32'hFFFF_FF9C, 32'd7, 32'h1c00_0080));
    for (int c = 0; c <= 32; c++) step();
    chk("bp_valid", 32'(bus.es_to_ms_valid), 32'd1);
    chk("bp_result", res(), 32'hFFFF_FFF2);
    held = res();
    bus.ds_to_es_valid = 1'b1;
    bus.ds_to_es_bus = mk(4'b0, 12'h001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'd0, 32'h10, 32'h20, 32'h1c00_0084);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_state", 32'(dbg_state), 32'd2);
      chk("bp_hold_result", res(), held);
      chk("bp_hold_ctl", 32'({bus.es_allowin, bus.es_to_ms_valid}), 32'b01);
    end
    bus.ms_allowin = 1'b1;
    #1;
    chk("bp_release_allowin", 32'(bus.es_allowin), 32'd1);
    step();
    bus.ds_to_es_valid = 1'b0;
    chk("bp_next_state", 32'(dbg_state), 32'd0);
    chk("bp_next_valid", 32'(bus.es_to_ms_valid), 32'd1);
    chk("bp_next_result", res(), 32'h30);
    step();
    chk("bp_next_gone", 32'(bus.es_to_ms_valid), 32'd0);

    // st.w 0x1000 + 8 <- 0xDEADBEEF
    issue(mk(4'b0, 12'h001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'd8, 32'h1000, 32'hDEAD_BEEF, 32'h1c00_0100));
    chk("st_en_we", 32'({bus.data_sram_en, bus.data_sram_we}), 32'h1F);
    chk("st_addr", bus.data_sram_addr, 32'h1008);
    chk("st_wdata", bus.data_sram_wdata, 32'hDEAD_BEEF);
    step();
    chk("st_once", 32'({bus.data_sram_en, bus.data_sram_we}), 32'd0);

    // ld.w 0x2000 + 4
    issue(mk(4'b0, 12'h001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'd4, 32'h2000, 32'h0, 32'h1c00_0104));
    chk("ld_en_we", 32'({bus.data_sram_en, bus.data_sram_we}), 32'h10);
    chk("ld_addr", bus.data_sram_addr, 32'h2004);
    chk("ld_blk_mem", 32'({bus.es_to_ds_bus[0], bus.es_to_ms_bus[70]}), 32'b11);
    step();
    chk("ld_once", 32'(bus.data_sram_en), 32'd0);

    // Reset in the middle of a divide
    issue(mk(4'b0001, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'd0, 32'h1000, 32'd3, 32'h1c00_0200));
    for (int c = 0; c < 10; c++) step();
    chk("mid_busy", 32'(dbg_state), 32'd1);
    resetn = 1'b0;
    #1;
    chk("abort_ctl", 32'({bus.es_to_ms_valid, bus.es_allowin, bus.es_to_ds_bus[0]}), 32'b010);
    chk("abort_state", 32'(dbg_state), 32'd0);
    #2;
    resetn = 1'b1;
    step();
    chk("post_rst_empty", 32'({bus.es_to_ms_valid, bus.es_allowin, dbg_state}), 32'b0100);
    run_div("divwu_after_rst", 4'b0100, 32'd100, 32'd7, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
